// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through / no-write-allocate byte cache in front of a
// 1-cycle-latency backing RAM, with hit/miss counters and a global flush.
module cache_ctrl #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [10:0] addr,
  input  logic [7:0]  wdata,
  input  logic        flush,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic [10:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 11 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FILL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [7:0]       data_mem [LINES];

  logic [IDX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] tag, ftag;
  logic             hit;
  logic             accept;

  assign idx    = addr[IDX_W-1:0];
  assign tag    = addr[10:IDX_W];
  // mem_addr is loaded with the request address on every miss, so it doubles
  // as the captured address for the line fill.
  assign fidx   = mem_addr[IDX_W-1:0];
  assign ftag   = mem_addr[10:IDX_W];
  assign hit    = valid[idx] && (tag_mem[idx] == tag);
  assign accept = (state == S_IDLE) && req && !flush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (we)       state_nxt = S_WRITE;
          else if (hit) state_nxt = S_DONE;
          else          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_FILL;
      S_FILL:  state_nxt = S_DONE;
      S_WRITE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack      <= 1'b0;
      rdata    <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_wr   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      ack    <= (state_nxt == S_DONE);
      mem_wr <= (state_nxt == S_WRITE);
      if (accept) begin
        if (we || !hit) mem_addr <= addr;
        if (we)         mem_din  <= wdata;
        if (!we && hit) rdata    <= data_mem[idx];
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
        end
      end
      if (state == S_FILL) rdata <= mem_dout;
    end
  end

  // Valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            valid       <= '0;
    else if (state == S_IDLE && flush)  valid       <= '0;
    else if (state == S_FILL)           valid[fidx] <= 1'b1;
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (accept && we && hit) data_mem[idx] <= wdata;
    if (state == S_FILL) begin
      data_mem[fidx] <= mem_dout;
      tag_mem[fidx]  <= ftag;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl against a 1-cycle-latency RAM whose
// unwritten locations read back as the low byte of their address.
module tb_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [10:0] addr;
  logic [7:0]  wdata;
  logic        flush;
  logic        ack;
  logic [7:0]  rdata;
  logic [10:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int errors = 0;
  int checks = 0;

  cache_ctrl #(.IDX_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .flush    (flush),
    .ack      (ack),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_wr   (mem_wr),
    .mem_dout (mem_dout),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing RAM: preload mem[a] = a[7:0], overridden by any written byte.
  bit       wmask [2048];
  bit [7:0] wmem  [2048];
  always @(posedge clk) begin
    mem_dout <= wmask[mem_addr] ? wmem[mem_addr] : mem_addr[7:0];
    if (mem_wr) begin
      wmask[mem_addr] <= 1'b1;
      wmem[mem_addr]  <= mem_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, hold it until ack (bounded), then wait one cycle so
  // the controller is back in IDLE. lat=0 means no ack within the bound.
  task automatic access(input logic w, input logic [10:0] a, input logic [7:0] d,
                        output int lat, output int wrc,
                        output logic [10:0] wa, output logic [7:0] wd);
    req = 1'b1; we = w; addr = a; wdata = d;
    lat = 0; wrc = 0; wa = '0; wd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (mem_wr) begin
        wrc++;
        wa = mem_addr;
        wd = mem_din;
      end
      if (ack) begin
        lat = i;
        break;
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  int          lat, wrc, ackseen;
  logic [10:0] wa;
  logic [7:0]  wd;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",      ack,      0);
    chk("rst_rdata",    rdata,    0);
    chk("rst_mem_wr",   mem_wr,   0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din",  mem_din,  0);
    chk("rst_hit",      hit_cnt,  0);
    chk("rst_miss",     miss_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold read miss
    access(1'b0, 11'h025, 8'h00, lat, wrc, wa, wd);
    chk("rd1_lat",   lat,      3);
    chk("rd1_data",  rdata,    8'h25);
    chk("rd1_miss",  miss_cnt, 1);
    chk("rd1_hit",   hit_cnt,  0);
    chk("rd1_maddr", mem_addr, 11'h025);
    chk("rd1_wr",    wrc,      0);

    // Read hit
    access(1'b0, 11'h025, 8'h00, lat, wrc, wa, wd);
    chk("rd2_lat",   lat,      1);
    chk("rd2_data",  rdata,    8'h25);
    chk("rd2_hit",   hit_cnt,  1);
    chk("rd2_miss",  miss_cnt, 1);
    chk("rd2_maddr", mem_addr, 11'h025);

    // Write hit
    access(1'b1, 11'h025, 8'hA5, lat, wrc, wa, wd);
    chk("wr_lat",   lat,      2);
    chk("wr_pulse", wrc,      1);
    chk("wr_addr",  wa,       11'h025);
    chk("wr_din",   wd,       8'hA5);
    chk("wr_hit",   hit_cnt,  2);
    chk("wr_rdata", rdata,    8'h25);
    chk("wr_wroff", mem_wr,   0);

    access(1'b0, 11'h025, 8'h00, lat, wrc, wa, wd);
    chk("rd3_lat",  lat,     1);
    chk("rd3_data", rdata,   8'hA5);
    chk("rd3_hit",  hit_cnt, 3);

    // Conflict on index 5
    access(1'b0, 11'h035, 8'h00, lat, wrc, wa, wd);
    chk("rd4_lat",  lat,      3);
    chk("rd4_data", rdata,    8'h35);
    access(1'b0, 11'h025, 8'h00, lat, wrc, wa, wd);
    chk("rd5_lat",  lat,      3);
    chk("rd5_data", rdata,    8'hA5);
    chk("rd5_miss", miss_cnt, 3);
    chk("rd5_hit",  hit_cnt,  3);

    // Flush together with a read request
    req = 1'b1; we = 1'b0; addr = 11'h035; flush = 1'b1;
    @(posedge clk); #1;
    chk("fl_ack",  ack,      0);
    chk("fl_miss", miss_cnt, 3);
    chk("fl_hit",  hit_cnt,  3);
    flush = 1'b0;
    access(1'b0, 11'h035, 8'h00, lat, wrc, wa, wd);
    chk("fl_lat",  lat,      3);
    chk("fl_data", rdata,    8'h35);
    chk("fl_miss2", miss_cnt, 4);

    // Flush alone invalidates a line that would otherwise hit
    access(1'b0, 11'h035, 8'h00, lat, wrc, wa, wd);
    chk("pre_fl_lat", lat,     1);
    chk("pre_fl_hit", hit_cnt, 4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    access(1'b0, 11'h035, 8'h00, lat, wrc, wa, wd);
    chk("post_fl_lat",  lat,      3);
    chk("post_fl_miss", miss_cnt, 5);

    // Reset during WRITE drops mem_wr asynchronously and skips the RAM write
    req = 1'b1; we = 1'b1; addr = 11'h100; wdata = 8'h77;
    @(posedge clk); #1;
    chk("wrst_wr_on", mem_wr, 1);
    rst = 1'b1; req = 1'b0;
    #1;
    chk("wrst_wr_off", mem_wr,   0);
    chk("wrst_hit",    hit_cnt,  0);
    chk("wrst_miss",   miss_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 11'h100, 8'h00, lat, wrc, wa, wd);
    chk("wrst_rd_lat",  lat,   3);
    chk("wrst_rd_data", rdata, 8'h00);

    // Reset during FILL of read 0x046
    req = 1'b1; we = 1'b0; addr = 11'h046;
    @(posedge clk); #1;
    chk("frst_maddr", mem_addr, 11'h046);
    @(posedge clk); #1;
    chk("frst_ack_fill", ack, 0);
    rst = 1'b1; req = 1'b0;
    #1;
    chk("frst_miss", miss_cnt, 0);
    ackseen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack) ackseen++;
    end
    chk("frst_noack", ackseen, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 11'h046, 8'h00, lat, wrc, wa, wd);
    chk("frst_rd_lat",  lat,      3);
    chk("frst_rd_data", rdata,    8'h46);
    chk("frst_rd_miss", miss_cnt, 1);
    chk("frst_rd_hit",  hit_cnt,  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 The block SHALL have one parameter: IDX_W, default 4, index width; the cache SHALL hold 2**IDX_W one-byte lines, and TAG_W = 11-IDX_W.
REQ-002 The block SHALL have these ports (clock and reset first):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  CPU access request, held until ack
- we  in  1  1=write, 0=read; stable while req
- addr  in  11  CPU byte address; stable while req
- wdata  in  8  CPU write data; stable while req
- flush  in  1  invalidate all lines
- ack  out  1  one-cycle completion pulse
- rdata  out  8  read data, valid when ack=1 for a read
- mem_addr  out  11  backing RAM address
- mem_din  out  8  backing RAM write data
- mem_wr  out  1  backing RAM write enable
- mem_dout  in  8  backing RAM read data, valid one cycle after the address is sampled
- hit_cnt  out  16  saturating hit counter
- miss_cnt  out  16  saturating miss counter

Function
REQ-003 The cache SHALL be direct-mapped: index = addr[IDX_W-1:0], tag = addr[10:IDX_W]; per line: valid bit, tag, data byte.
REQ-004 The cache SHALL be write-through with no-write-allocate.
REQ-005 The FSM SHALL have states IDLE, FETCH, FILL, WRITE and DONE; all outputs SHALL be registered.
REQ-006 In IDLE with flush=1, all valid bits SHALL clear at that edge, req SHALL be ignored that cycle, and the state SHALL stay IDLE.
REQ-007 In IDLE with req=1 and flush=0, the block SHALL register addr, we and wdata and compute hit = valid[index] && tag match.
REQ-008 Read hit: IDLE->DONE; rdata = line data; ack=1 in the cycle after the req-sampling edge (latency 1).
REQ-009 Read miss: IDLE->FETCH->FILL->DONE.
- FETCH: mem_addr = captured addr, mem_wr=0.
- FILL->DONE edge: mem_dout written to the line, tag updated, valid=1, rdata = mem_dout.
- ack is asserted 3 cycles after the req-sampling edge.
REQ-010 Write: IDLE->WRITE->DONE.
- WRITE: mem_wr=1, mem_addr = captured addr, mem_din = captured wdata.
- On a write hit, the line data SHALL update on the IDLE->WRITE edge.
- On a write miss, cache state SHALL be unchanged.
- ack is asserted 2 cycles after the req-sampling edge.
REQ-011 mem_wr SHALL be 1 only in WRITE; mem_addr and mem_din SHALL hold their last values otherwise.
REQ-012 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; req and flush SHALL be ignored during DONE.
REQ-013 rdata SHALL hold its value until the next read completes; ack=0 in every state except DONE.
REQ-014 flush outside IDLE SHALL be ignored; the requester holds flush until it is sampled in IDLE.
REQ-015 hit_cnt SHALL increment by 1 per accepted hit (read or write), and miss_cnt per accepted miss, at the IDLE exit edge; both SHALL saturate at 16'hFFFF.
REQ-016 Simultaneous flush and req in IDLE: flush SHALL win, and req SHALL be served in the next IDLE cycle as a miss.

Reset
REQ-017 While rst=1, the block SHALL set: state=IDLE, all valid bits=0, ack=0, rdata=0, mem_wr=0, mem_addr=0, mem_din=0, hit_cnt=0, miss_cnt=0. Tag and data arrays need not be reset.
REQ-018 Reset asserted in FETCH, FILL or WRITE SHALL abort the access: no fill, no ack, and mem_wr=0 immediately (asynchronous).

Verification
REQ-019 The bench SHALL use a 1-cycle-latency RAM model preloaded with mem[a] = a[7:0] and cover:
- Read 0x025 after reset -> FETCH, FILL; ack 3 cycles later; rdata=0x25; miss_cnt=1.
- Repeat read 0x025 -> ack 1 cycle later; rdata=0x25; hit_cnt=1; mem_addr unchanged.
- Write 0x025<=0xA5 (hit), then read 0x025 -> mem_wr pulses 1 cycle with mem_din=0xA5; read hits with rdata=0xA5.
- Read 0x035 (same index, IDX_W=4), then read 0x025 -> both miss; second returns 0xA5 from RAM; miss_cnt=3.
- flush in IDLE together with req read 0x035 -> the following access misses; no ack in the flush cycle.
- rst during FILL of read 0x046 -> ack never asserted; a subsequent read 0x046 misses and returns 0x46.
